// File: rtl/temp_link_tx.sv
// Byte-serial parallel-link transmitter: one 32-bit word goes out as four bytes, MSB first.
// Each byte is framed by one strobe pulse that the receiver samples on its rising edge.
module temp_link_tx #(
   parameter int HALF_CYC  = 4,
   parameter int SETUP_CYC = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tx_valid,
   input  logic [31:0] tx_data,
   output logic        tx_ready,
   output logic [7:0]  byte_out,
   output logic        strobe,
   output logic        frame,
   output logic        done
);
   localparam int MAXC = (HALF_CYC > SETUP_CYC) ? HALF_CYC : SETUP_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HALF_END  = CW'(HALF_CYC - 1);
   localparam logic [CW-1:0] SETUP_END = CW'(SETUP_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [31:0]   shadow;

   function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    pick = w[31:24];
         2'd1:    pick = w[23:16];
         2'd2:    pick = w[15:8];
         default: pick = w[7:0];
      endcase
   endfunction

   assign tx_ready = (state == IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= 2'd0;
         shadow   <= 32'd0;
         byte_out <= 8'd0;
         strobe   <= 1'b0;
         frame    <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (tx_valid) begin
               shadow   <= tx_data;
               idx      <= 2'd0;
               byte_out <= pick(tx_data, 2'd0);
               frame    <= 1'b1;
               cnt      <= '0;
               state    <= SETUP;
            end
            SETUP: if (cnt == SETUP_END) begin
               cnt    <= '0;
               strobe <= 1'b1;
               state  <= HIGH;
            end else cnt <= cnt + 1'b1;
            HIGH: if (cnt == HALF_END) begin
               cnt    <= '0;
               strobe <= 1'b0;
               state  <= LOW;
            end else cnt <= cnt + 1'b1;
            LOW: if (cnt == HALF_END) begin
               cnt <= '0;
               // Data only moves while strobe is low, so it is stable across setup and high time.
               if (idx == 2'd3) begin
                  frame    <= 1'b0;
                  byte_out <= 8'd0;
                  done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  idx      <= idx + 2'd1;
                  byte_out <= pick(shadow, idx + 2'd1);
                  state    <= SETUP;
               end
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_temp_link_tx.sv
// Directed bench for temp_link_tx: default-parameter instance plus a minimum-parameter
// instance, each with a loopback receiver that shifts in byte_out on every strobe rise.
module tb_temp_link_tx;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tx_valid0 = 1'b0, tx_valid1 = 1'b0;
   logic [31:0] tx_data = 32'd0;
   logic        tx_ready0, strobe0, frame0, done0;
   logic        tx_ready1, strobe1, frame1, done1;
   logic [7:0]  byte_out0, byte_out1;

   int          n_cmp = 0, n_err = 0;
   logic [31:0] rx_word0 = 32'd0, rx_word1 = 32'd0;
   int          rx_cnt0 = 0, rx_cnt1 = 0;

   always #5 clock = ~clock;

   temp_link_tx dut0 (
      .clock(clock), .reset(reset), .tx_valid(tx_valid0), .tx_data(tx_data),
      .tx_ready(tx_ready0), .byte_out(byte_out0), .strobe(strobe0), .frame(frame0), .done(done0)
   );

   temp_link_tx #(.HALF_CYC(1), .SETUP_CYC(1)) dut1 (
      .clock(clock), .reset(reset), .tx_valid(tx_valid1), .tx_data(tx_data),
      .tx_ready(tx_ready1), .byte_out(byte_out1), .strobe(strobe1), .frame(frame1), .done(done1)
   );

   always @(posedge strobe0) begin
      rx_word0 <= {rx_word0[23:0], byte_out0};
      rx_cnt0  <= rx_cnt0 + 1;
   end
   always @(posedge strobe1) begin
      rx_word1 <= {rx_word1[23:0], byte_out1};
      rx_cnt1  <= rx_cnt1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Acceptance happens at the next rising edge (k=0); checks {frame,done,strobe,byte_out}
   // after every edge up to k=W, then the loopback capture.
   task automatic check_frame(input bit m, input logic [31:0] w, input int s, input int h,
                              input int chg_k, input logic [31:0] chg_d, input bit hold);
      int per, wt, c0, b, p;
      logic [10:0] obs, exp;
      per = s + 2*h;
      wt  = 4*per;
      c0  = m ? rx_cnt1 : rx_cnt0;
      for (int k = 0; k <= wt; k++) begin
         @(negedge clock);
         obs = m ? {frame1, done1, strobe1, byte_out1} : {frame0, done0, strobe0, byte_out0};
         if (k < wt) begin
            b   = k / per;
            p   = k % per;
            exp = {1'b1, 1'b0, (p >= s && p < s + h), w[31-8*b -: 8]};
         end else exp = {1'b0, 1'b1, 1'b0, 8'h00};
         chk($sformatf("m%0d w=%h k=%0d", m, w, k), {21'd0, obs}, {21'd0, exp});
         if (k == 0) begin
            if (m) tx_valid1 = hold; else tx_valid0 = hold;
         end
         if (k == chg_k) tx_data = chg_d;
      end
      chk($sformatf("m%0d ready_at_end", m), {31'd0, m ? tx_ready1 : tx_ready0}, 32'd1);
      chk($sformatf("m%0d rx_pulses", m), (m ? rx_cnt1 : rx_cnt0) - c0, 32'd4);
      chk($sformatf("m%0d rx_word", m), m ? rx_word1 : rx_word0, w);
   endtask

   initial begin
      // Reset held from time zero, no clock edge yet
      #3;
      chk("rst_outs0", {21'd0, frame0, done0, strobe0, byte_out0}, 32'd0);
      chk("rst_outs1", {21'd0, frame1, done1, strobe1, byte_out1}, 32'd0);
      chk("rst_ready", {30'd0, tx_ready0, tx_ready1}, 32'd3);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("ready_after_rst", {30'd0, tx_ready0, tx_ready1}, 32'd3);

      // Default-parameter word
      tx_data = 32'hA5C3_0F81; tx_valid0 = 1'b1;
      check_frame(1'b0, 32'hA5C3_0F81, 1, 4, -1, 32'd0, 1'b0);
      @(negedge clock);
      chk("done_one_cycle", {31'd0, done0}, 32'd0);

      // Back-to-back: valid held, second word offered right after first acceptance
      tx_data = 32'h0000_0001; tx_valid0 = 1'b1;
      check_frame(1'b0, 32'h0000_0001, 1, 4, 0, 32'hFFFF_FFFF, 1'b1);
      check_frame(1'b0, 32'hFFFF_FFFF, 1, 4, -1, 32'd0, 1'b0);

      // Mid-frame tx_data change during byte 1
      @(negedge clock);
      tx_data = 32'hDEAD_BEEF; tx_valid0 = 1'b1;
      check_frame(1'b0, 32'hDEAD_BEEF, 1, 4, 12, 32'h1234_5678, 1'b0);

      // Reset during byte 2 (strobe high at k=20)
      @(negedge clock);
      tx_data = 32'hCAFE_F00D; tx_valid0 = 1'b1;
      @(negedge clock);
      tx_valid0 = 1'b0;
      repeat (20) @(negedge clock);
      chk("pre_rst_strobe", {23'd0, strobe0, byte_out0}, {23'd1, 8'hF0});
      #1 reset = 1'b1;
      #1;
      chk("midrst_outs", {21'd0, frame0, done0, strobe0, byte_out0}, 32'd0);
      chk("midrst_ready", {31'd0, tx_ready0}, 32'd1);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("post_rst_quiet%0d", i), {29'd0, frame0, done0, strobe0}, 32'd0);
      end
      tx_data = 32'h0000_00FF; tx_valid0 = 1'b1;
      check_frame(1'b0, 32'h0000_00FF, 1, 4, -1, 32'd0, 1'b0);

      // Minimum parameters: 12-cycle frame
      @(negedge clock);
      tx_data = 32'hA5C3_0F81; tx_valid1 = 1'b1;
      check_frame(1'b1, 32'hA5C3_0F81, 1, 1, -1, 32'd0, 1'b0);
      chk("mode0_idle", {31'd0, frame0}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
